// File: rtl/mips_fetch_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE sequencer holding instruction memory and PC.
// Optional execute-wait watchdog enabled by defining FETCH_SEQ_WATCHDOG_EN.
module mips_fetch_sequencer #(
  parameter int                ADDR_W      = 10,
  parameter int                DATA_W      = 32,
  parameter logic [DATA_W-1:0] HALT_WORD   = 32'hFFFF_FFFF,
  parameter int                WDOG_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              imem_we,
  input  logic [ADDR_W-1:0] imem_waddr,
  input  logic [DATA_W-1:0] imem_wdata,
  input  logic              exec_done,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        state,
  output logic [31:0]       retired,
  output logic              done,
  output logic              err
);

  // Handshake: the datapath holds exec_done (and redirect/redirect_addr) for
  // as long as it likes; the sequencer consumes them on the first EXECUTE edge
  // where exec_done is high and ignores them everywhere else.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam int                DEPTH  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  if (WDOG_CYCLES < 1) begin : g_wdog_range
    $error("WDOG_CYCLES must be at least 1");
  end

  logic [DATA_W-1:0] imem [DEPTH];

  state_t            state_q, state_next;
  logic [ADDR_W-1:0] pc_q, pc_next;
  logic [DATA_W-1:0] instr_q;
  logic [31:0]       retired_q, retired_next;
  logic              instr_valid_q, done_q, err_q, err_next;
  logic              load_ir;
  logic              mem_we;

  assign mem_we = imem_we && (state_q == S_IDLE || state_q == S_HALT);

`ifdef FETCH_SEQ_WATCHDOG_EN
  localparam int WDOG_W = ($clog2(WDOG_CYCLES + 1) > 8) ? $clog2(WDOG_CYCLES + 1) : 8;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_q;
  logic              wdog_expired;

  assign wdog_expired = (wdog_q == WDOG_LAST);

  // Counts cycles spent in the current EXECUTE; zero on every entry.
  always_ff @(posedge clk) begin
    if (rst || state_q != S_EXEC) wdog_q <= '0;
    else                          wdog_q <= wdog_q + WDOG_W'(1);
  end
`endif

  always_comb begin
    state_next   = state_q;
    pc_next      = pc_q;
    retired_next = retired_q;
    err_next     = err_q;
    load_ir      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_next = S_FETCH;
          pc_next    = '0;
        end
      end
      S_FETCH: begin
        load_ir    = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        state_next = (instr_q == HALT_WORD) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (exec_done) begin
          retired_next = retired_q + 32'd1;
          pc_next      = redirect ? redirect_addr : pc_q + PC_ONE;
          state_next   = S_FETCH;
        end
`ifdef FETCH_SEQ_WATCHDOG_EN
        else if (wdog_expired) begin
          state_next = S_HALT;
          err_next   = 1'b1;
        end
`endif
      end
      S_HALT: begin
        if (start) begin
          state_next   = S_FETCH;
          pc_next      = '0;
          retired_next = '0;
          err_next     = 1'b0;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Memory is deliberately outside reset so a program survives rst.
  always_ff @(posedge clk) begin
    if (mem_we) imem[imem_waddr] <= imem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      instr_q       <= '0;
      retired_q     <= '0;
      instr_valid_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_next;
      pc_q          <= pc_next;
      if (load_ir) instr_q <= imem[pc_q];
      retired_q     <= retired_next;
      instr_valid_q <= (state_next == S_DECODE);
      done_q        <= (state_next == S_HALT);
      err_q         <= err_next;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign state       = state_q;
  assign retired     = retired_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mips_fetch_sequencer.sv
// Randomized bench for mips_fetch_sequencer against an instruction-level model
// (memory image, program counter, retired count).
module tb_mips_fetch_sequencer;

  localparam int          ADDR_W    = 4;
  localparam int          DATA_W    = 32;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam int          WDOG      = 4;
  localparam int          DEPTH     = 2 ** ADDR_W;
`ifdef FETCH_SEQ_WATCHDOG_EN
  localparam int          GAP_MAX   = WDOG - 1;
`else
  localparam int          GAP_MAX   = 12;
`endif

  logic              clk, rst, start, imem_we, exec_done, redirect;
  logic [ADDR_W-1:0] imem_waddr, redirect_addr, pc;
  logic [DATA_W-1:0] imem_wdata, instr;
  logic              instr_valid, done, err;
  logic [2:0]        state;
  logic [31:0]       retired;

  mips_fetch_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .HALT_WORD(HALT_WORD), .WDOG_CYCLES(WDOG)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .exec_done(exec_done),
    .redirect(redirect), .redirect_addr(redirect_addr), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .state(state), .retired(retired),
    .done(done), .err(err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] mem_m [DEPTH];
  logic [ADDR_W-1:0] m_pc;
  logic [31:0]       m_retired;
  int                n_checks = 0;
  int                n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_pc"}, pc, 0);
    check({tag, "_instr"}, instr, 0);
    check({tag, "_retired"}, retired, 0);
    check({tag, "_valid"}, instr_valid, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_word(input int addr, input logic [DATA_W-1:0] data);
    imem_we = 1'b1;
    imem_waddr = ADDR_W'(addr);
    imem_wdata = data;
    mem_m[addr] = data;
    step();
    imem_we = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] w;
    w = $urandom;
    if (w == HALT_WORD) w = '0;
    return w;
  endfunction

  // Start pulse from IDLE/HALT, optionally with a same-cycle memory write.
  task automatic kick(input bit wr, input int addr, input logic [DATA_W-1:0] data);
    start = 1'b1;
    imem_we = wr;
    imem_waddr = ADDR_W'(addr);
    imem_wdata = data;
    if (wr) mem_m[addr] = data;
    step();
    start = 1'b0;
    imem_we = 1'b0;
    m_pc = '0;
    m_retired = '0;
  endtask

  // Walks the program from the FETCH cycle after kick(). redir_mode:
  // 0 none, 1 random, 2 pc 1 jumps to 5. Resets the DUT mid-EXECUTE when
  // max_instr instructions have retired without reaching a halt.
  task automatic run_prog(input int max_instr, input int gap_lo, input int gap_hi,
                          input int redir_mode, output int cycles, output bit halted);
    int gap;
    bit rd;
    logic [ADDR_W-1:0] nxt;
    cycles = 1;
    halted = 1'b0;
    check("fetch_state", state, 1);
    for (int n = 0; n <= max_instr; n++) begin
      step(); cycles++;
      check("dec_state", state, 2);
      check("dec_valid", instr_valid, 1);
      check("dec_instr", instr, mem_m[m_pc]);
      check("dec_pc", pc, m_pc);
      if (mem_m[m_pc] == HALT_WORD) begin
        step(); cycles++;
        check("halt_state", state, 4);
        check("halt_done", done, 1);
        check("halt_err", err, 0);
        check("halt_valid", instr_valid, 0);
        check("halt_pc", pc, m_pc);
        check("halt_retired", retired, m_retired);
        halted = 1'b1;
        return;
      end
      step(); cycles++;
      check("exe_state", state, 3);
      check("exe_valid", instr_valid, 0);
      if (n == max_instr) begin
        rst = 1'b1; exec_done = 1'b1; redirect = 1'b1;
        step();
        rst = 1'b0; exec_done = 1'b0; redirect = 1'b0;
        check_reset("mid_rst");
        m_pc = '0;
        m_retired = '0;
        return;
      end
      gap = $urandom_range(gap_hi, gap_lo);
      for (int w = 0; w < gap; w++) begin
        imem_we = 1'($urandom_range(1, 0));
        imem_waddr = ADDR_W'($urandom);
        imem_wdata = $urandom;
        start = 1'($urandom_range(1, 0));
        redirect = 1'($urandom_range(1, 0));
        redirect_addr = ADDR_W'($urandom);
        step(); cycles++;
        check("wait_state", state, 3);
        check("wait_retired", retired, m_retired);
        check("wait_pc", pc, m_pc);
      end
      imem_we = 1'b0;
      start = 1'b0;
      rd = (redir_mode == 1) ? ($urandom_range(3, 0) == 0) : (redir_mode == 2 && m_pc == 1);
      if (rd) nxt = (redir_mode == 2) ? ADDR_W'(5) : ADDR_W'($urandom);
      else    nxt = ADDR_W'((int'(m_pc) + 1) % DEPTH);
      redirect = rd;
      redirect_addr = rd ? nxt : ADDR_W'($urandom);
      exec_done = 1'b1;
      step(); cycles++;
      exec_done = 1'b0;
      redirect = 1'b0;
      m_pc = nxt;
      m_retired = m_retired + 32'd1;
      check("ret_state", state, 1);
      check("ret_pc", pc, m_pc);
      check("ret_count", retired, m_retired);
    end
  endtask

  // ---------------- scenarios ----------------
  int cyc;
  bit halted;

  initial begin
    rst = 1'b1; start = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    exec_done = 1'b0; redirect = 1'b0; redirect_addr = '0;
    m_pc = '0; m_retired = '0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    repeat (3) step();
    check_reset("reset");
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) load_word(i, 32'h0);

    // Three-word program, exec_done answered immediately.
    load_word(0, 32'h1);
    load_word(1, 32'h2);
    load_word(2, HALT_WORD);
    kick(1'b0, 0, '0);
    run_prog(10, 0, 0, 0, cyc, halted);
    check("basic_halted", halted, 1);
    check("basic_latency", cyc, 9);
    check("basic_retired", retired, 2);

    // Jump from pc 1 to 5.
    load_word(0, 32'h10);
    load_word(1, 32'h11);
    load_word(5, 32'h15);
    load_word(6, HALT_WORD);
    kick(1'b0, 0, '0);
    run_prog(10, 0, 2, 2, cyc, halted);
    check("redir_halted", halted, 1);
    check("redir_pc", pc, 6);

    // Long execute wait with ignored writes/starts while busy.
    load_word(0, 32'h20);
    load_word(1, 32'h21);
    load_word(2, HALT_WORD);
    kick(1'b0, 0, '0);
    run_prog(10, GAP_MAX, GAP_MAX, 0, cyc, halted);
    check("wait_halted", halted, 1);

    // Start together with a write to address 0.
    kick(1'b1, 0, 32'h77);
    run_prog(30, 0, GAP_MAX, 1, cyc, halted);

    // All words non-halt: pc wraps; reset lands in EXECUTE at pc 3.
    if (halted) kick(1'b0, 0, '0);
    else begin
      for (int i = 0; i < DEPTH; i++) load_word(i, rand_word());
      kick(1'b0, 0, '0);
    end
    for (int i = 0; i < DEPTH; i++) mem_m[i] = mem_m[i];
    if (halted) begin
      rst = 1'b1; step(); rst = 1'b0;
      check_reset("pre_wrap_rst");
      for (int i = 0; i < DEPTH; i++) load_word(i, rand_word());
      kick(1'b0, 0, '0);
    end
    run_prog(19, 0, 0, 0, cyc, halted);
    check("wrap_not_halted", halted, 0);
    load_word(2, HALT_WORD);
    kick(1'b0, 0, '0);
    run_prog(10, 0, 0, 0, cyc, halted);
    check("after_rst_halted", halted, 1);

    // Random programs with random redirects and waits.
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < DEPTH; i++) load_word(i, rand_word());
      load_word($urandom_range(DEPTH - 1, 1), HALT_WORD);
      kick(1'($urandom_range(1, 0)), 0, rand_word());
      run_prog(30, 0, GAP_MAX, 1, cyc, halted);
      if (halted) begin
        rst = 1'b1; step(); rst = 1'b0;
        check_reset("rand_rst");
      end
    end

`ifdef FETCH_SEQ_WATCHDOG_EN
    load_word(0, 32'h5);
    load_word(1, HALT_WORD);
    kick(1'b0, 0, '0);
    step();
    check("wd_dec_state", state, 2);
    for (int k = 0; k < WDOG; k++) begin
      step();
      check("wd_exe_state", state, 3);
    end
    step();
    check("wd_state", state, 4);
    check("wd_err", err, 1);
    check("wd_done", done, 1);
    check("wd_pc", pc, 0);
    check("wd_retired", retired, 0);
    kick(1'b0, 0, '0);
    check("wd_clear_err", err, 0);
    check("wd_clear_done", done, 0);
    check("wd_restart_state", state, 1);
`endif

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
